// File: rtl/hub75_rx_if.sv
// HUB75 receiver bus: panel-side input lanes plus the reconstructed-row outputs.
// The slave modport is the receiver; the master modport is the panel driver
// that also consumes the reported rows.
interface hub75_rx_if #(
    parameter int COLS   = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic                hub_clk;
    logic                hub_latch;
    logic                hub_noe;
    logic [5:0]          hub_rgb;
    logic [ADDR_W-1:0]   hub_addr;
    logic [6*COLS-1:0]   row_data;
    logic [ADDR_W-1:0]   row_addr;
    logic [CNT_W-1:0]    on_time;
    logic                row_valid;
    logic                col_err;

    modport master (
        output hub_clk, hub_latch, hub_noe, hub_rgb, hub_addr,
        input  row_data, row_addr, on_time, row_valid, col_err
    );

    modport slave (
        input  hub_clk, hub_latch, hub_noe, hub_rgb, hub_addr,
        output row_data, row_addr, on_time, row_valid, col_err
    );
endinterface

// File: rtl/hub75_rx.sv
// HUB75 panel receiver: oversamples the panel bus on clk, rebuilds each
// shifted row, and reports it with its address and the number of clk cycles
// output-enable was active for that row.
// Optional macro HUB75_RX_SYNC_EN: adds a 2-flop synchronizer ahead of the
// input register for a hub_* bus that is asynchronous to clk.
module hub75_rx #(
    parameter int COLS   = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    hub75_rx_if.slave  bus
);
    localparam int IN_W = 3 + 6 + ADDR_W;
    localparam int CC_W = $clog2(COLS + 2);
    localparam logic [CC_W-1:0] CC_COLS = CC_W'(COLS);
    localparam logic [CC_W-1:0] CC_MAX  = CC_W'(COLS + 1);

    typedef enum logic [1:0] {IDLE, HOLD, ON, DONE} state_t;

    logic [IN_W-1:0]         raw;
    logic [IN_W-1:0]         samp;
    logic                    s_clk, s_latch, s_noe;
    logic [5:0]              s_rgb;
    logic [ADDR_W-1:0]       s_addr;
    logic                    prev_clk, prev_latch;
    logic                    px_rise, lt_rise;
    logic [5:0][COLS-1:0]    sr_reg;
    logic [5:0][COLS-1:0]    sr_next;
    logic [CC_W-1:0]         col_cnt;
    logic [6*COLS-1:0]       cap_data;
    logic [ADDR_W-1:0]       cap_addr;
    logic                    cap_err;
    logic [CNT_W-1:0]        on_cnt;
    state_t                  state, state_next;
    logic                    report, cnt_start, cnt_inc;

    assign raw = {bus.hub_clk, bus.hub_latch, bus.hub_noe, bus.hub_rgb, bus.hub_addr};

`ifdef HUB75_RX_SYNC_EN
    logic [IN_W-1:0] sync1, sync2;

    // Two synchronizer stages, then the common sampling register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            samp  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            samp  <= sync2;
        end
    end
`else
    // Single sampling register; hub_* is driven synchronous to clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) samp <= '0;
        else      samp <= raw;
    end
`endif

    assign s_clk   = samp[IN_W-1];
    assign s_latch = samp[IN_W-2];
    assign s_noe   = samp[IN_W-3];
    assign s_rgb   = samp[ADDR_W +: 6];
    assign s_addr  = samp[ADDR_W-1:0];

    assign px_rise = s_clk & ~prev_clk;
    assign lt_rise = s_latch & ~prev_latch;

    // Edge-detect history of the sampled pixel clock and latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_clk   <= 1'b0;
            prev_latch <= 1'b0;
        end else begin
            prev_clk   <= s_clk;
            prev_latch <= s_latch;
        end
    end

    // Per-lane shift: first-clocked pixel migrates up to index COLS-1
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_lane
            assign sr_next[gi] = px_rise ? {sr_reg[gi][COLS-2:0], s_rgb[gi]} : sr_reg[gi];
        end
    endgenerate

    // Shift registers advance on every pixel-clock rise, whatever the FSM state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_reg <= '0;
        else      sr_reg <= sr_next;
    end

    // Pixel counter, restarted by latch; a coincident pixel belongs to the next row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
        end else if (lt_rise) begin
            col_cnt <= px_rise ? CC_W'(1) : '0;
        end else if (px_rise && col_cnt != CC_MAX) begin
            col_cnt <= col_cnt + CC_W'(1);
        end
    end

    // Latch capture held privately so an in-flight report keeps its own row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_data <= '0;
            cap_addr <= '0;
            cap_err  <= 1'b0;
        end else if (lt_rise) begin
            cap_data <= sr_reg;
            cap_addr <= s_addr;
            cap_err  <= (col_cnt != CC_COLS);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // FSM next state; a latch always wins over the output-enable level
    always_comb begin
        state_next = state;
        report     = 1'b0;
        cnt_start  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (lt_rise) state_next = HOLD;
            end
            HOLD: begin
                if (lt_rise) begin
                    state_next = HOLD;
                end else if (!s_noe) begin
                    state_next = ON;
                    cnt_start  = 1'b1;
                end
            end
            ON: begin
                if (lt_rise) begin
                    state_next = HOLD;
                    report     = 1'b1;
                end else if (s_noe) begin
                    state_next = DONE;
                    report     = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                state_next = lt_rise ? HOLD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // On-time counter, saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on_cnt <= '0;
        end else if (cnt_start) begin
            on_cnt <= CNT_W'(1);
        end else if (cnt_inc && on_cnt != {CNT_W{1'b1}}) begin
            on_cnt <= on_cnt + CNT_W'(1);
        end
    end

    // Row report: outputs update together with the one-cycle valid pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.row_valid <= 1'b0;
            bus.row_data  <= '0;
            bus.row_addr  <= '0;
            bus.on_time   <= '0;
            bus.col_err   <= 1'b0;
        end else begin
            bus.row_valid <= report;
            if (report) begin
                bus.row_data <= cap_data;
                bus.row_addr <= cap_addr;
                bus.on_time  <= on_cnt;
                bus.col_err  <= cap_err;
            end
        end
    end
endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx with COLS=4; a second instance with CNT_W=4
// shares the same panel inputs to exercise on-time saturation.
module tb_hub75_rx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   valid_cnt = 0;
    int   base;
    logic [23:0] last_data;
    logic [4:0]  last_addr;
    logic [15:0] last_on;
    logic        last_err;
    logic [3:0]  last_on4;

    hub75_rx_if #(.COLS(4), .ADDR_W(5), .CNT_W(16)) bus();
    hub75_rx_if #(.COLS(4), .ADDR_W(5), .CNT_W(4))  bus4();

    assign bus4.hub_clk   = bus.hub_clk;
    assign bus4.hub_latch = bus.hub_latch;
    assign bus4.hub_noe   = bus.hub_noe;
    assign bus4.hub_rgb   = bus.hub_rgb;
    assign bus4.hub_addr  = bus.hub_addr;

    hub75_rx #(.COLS(4), .ADDR_W(5), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    hub75_rx #(.COLS(4), .ADDR_W(5), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    // Record each reported row, one line per row
    always @(negedge clk) begin
        if (bus.row_valid) begin
            valid_cnt <= valid_cnt + 1;
            last_data <= bus.row_data;
            last_addr <= bus.row_addr;
            last_on   <= bus.on_time;
            last_err  <= bus.col_err;
            $display("row addr=%0d data=%06h on_time=%0d col_err=%0b",
                     bus.row_addr, bus.row_data, bus.on_time, bus.col_err);
        end
        if (bus4.row_valid) last_on4 <= bus4.on_time;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input logic [5:0] rgb);
        bus.hub_rgb = rgb;
        bus.hub_clk = 1'b1;
        tick();
        bus.hub_clk = 1'b0;
        tick();
    endtask

    task automatic latch(input logic [4:0] addr);
        bus.hub_addr  = addr;
        bus.hub_latch = 1'b1;
        tick();
        bus.hub_latch = 1'b0;
        tick();
    endtask

    task automatic noe_pulse(input int n);
        bus.hub_noe = 1'b0;
        repeat (n) tick();
        bus.hub_noe = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        bus.hub_clk   = 1'b0;
        bus.hub_latch = 1'b0;
        bus.hub_noe   = 1'b1;
        bus.hub_rgb   = '0;
        bus.hub_addr  = '0;
        repeat (3) tick();

        // Reset state
        check("rst_valid", 32'(bus.row_valid), 32'h0);
        check("rst_data",  32'(bus.row_data),  32'h0);
        check("rst_addr",  32'(bus.row_addr),  32'h0);
        check("rst_on",    32'(bus.on_time),   32'h0);
        check("rst_err",   32'(bus.col_err),   32'h0);
        rst = 1'b1;
        repeat (2) tick();

        // Basic row: r0 = 1,0,0,1, addr 3, 10 cycles on
        base = valid_cnt;
        pixel(6'b100000); pixel(6'b000000); pixel(6'b000000); pixel(6'b100000);
        latch(5'd3);
        noe_pulse(10);
        check("basic_count", 32'(valid_cnt - base), 32'd1);
        check("basic_data",  32'(last_data), 32'h900000);
        check("basic_addr",  32'(last_addr), 32'd3);
        check("basic_on",    32'(last_on),   32'd10);
        check("basic_err",   32'(last_err),  32'd0);
        check("basic_on4",   32'(last_on4),  32'd10);

        // Short row flags col_err, a full row clears it
        pixel(6'b000001); pixel(6'b000001); pixel(6'b000001);
        latch(5'd1);
        noe_pulse(2);
        check("short_err",  32'(last_err),  32'd1);
        check("short_addr", 32'(last_addr), 32'd1);
        pixel(6'b000000); pixel(6'b000001); pixel(6'b000001); pixel(6'b000000);
        latch(5'd2);
        noe_pulse(2);
        check("full_err",  32'(last_err),  32'd0);
        check("full_data", 32'(last_data), 32'h000006);

        // Latch during ON after 5 low cycles closes the row and re-captures
        base = valid_cnt;
        pixel(6'b010000); pixel(6'b010000); pixel(6'b000000); pixel(6'b010000);
        latch(5'd5);
        bus.hub_noe = 1'b0;
        repeat (5) tick();
        bus.hub_addr  = 5'd6;
        bus.hub_latch = 1'b1;
        tick();
        bus.hub_latch = 1'b0;
        bus.hub_noe   = 1'b1;
        repeat (3) tick();
        check("onlt_count", 32'(valid_cnt - base), 32'd1);
        check("onlt_on",    32'(last_on),   32'd5);
        check("onlt_addr",  32'(last_addr), 32'd5);
        check("onlt_data",  32'(last_data), 32'h0D0000);
        noe_pulse(3);
        check("recap_count", 32'(valid_cnt - base), 32'd2);
        check("recap_addr",  32'(last_addr), 32'd6);
        check("recap_on",    32'(last_on),   32'd3);
        check("recap_err",   32'(last_err),  32'd1);

        // Pixel rise coincident with latch rise
        pixel(6'b100000); pixel(6'b100000); pixel(6'b100000); pixel(6'b100000);
        bus.hub_rgb   = 6'b000000;
        bus.hub_addr  = 5'd9;
        bus.hub_clk   = 1'b1;
        bus.hub_latch = 1'b1;
        tick();
        bus.hub_clk   = 1'b0;
        bus.hub_latch = 1'b0;
        tick();
        noe_pulse(2);
        check("coin_data", 32'(last_data), 32'hF00000);
        check("coin_err",  32'(last_err),  32'd0);
        pixel(6'b100000); pixel(6'b100000); pixel(6'b100000);
        latch(5'd10);
        noe_pulse(2);
        check("coin_next_err",  32'(last_err),  32'd0);
        check("coin_next_data", 32'(last_data), 32'h700000);

        // On-time saturation in the narrow-counter instance
        latch(5'd11);
        noe_pulse(40);
        check("sat_on16", 32'(last_on),  32'd40);
        check("sat_on4",  32'(last_on4), 32'd15);

        // Reset during ON clears outputs immediately and drops the row
        latch(5'd7);
        bus.hub_noe = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.row_valid), 32'h0);
        check("mid_rst_data",  32'(bus.row_data),  32'h0);
        check("mid_rst_addr",  32'(bus.row_addr),  32'h0);
        check("mid_rst_on",    32'(bus.on_time),   32'h0);
        check("mid_rst_err",   32'(bus.col_err),   32'h0);
        tick();
        bus.hub_noe = 1'b1;
        tick();
        rst = 1'b1;
        base = valid_cnt;
        bus.hub_noe = 1'b0;
        repeat (3) tick();
        bus.hub_noe = 1'b1;
        repeat (4) tick();
        check("post_rst_none", 32'(valid_cnt - base), 32'd0);
        latch(5'd8);
        noe_pulse(2);
        check("post_rst_count", 32'(valid_cnt - base), 32'd1);
        check("post_rst_addr",  32'(last_addr), 32'd8);
        check("post_rst_data",  32'(last_data), 32'h000000);
        check("post_rst_on",    32'(last_on),   32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
